add32_byte_serial_ctrl: RTL and testbench

Sequencer that performs 32-bit add/subtract by time-multiplexing one 8-bit Kogge-Stone adder slice over four cycles, LSB byte first, with the inter-byte carry held in a register. It sits between a requester with a valid/ready operand interface and a consumer with a valid/ready result interface. It is the area-reduced alternative to the fully unrolled 4×8-bit ripple-of-KS 32-bit adder.

---
 rtl/add32_byte_serial_ctrl.sv | 139 +++++++++++++
 tb/tb_add32_byte_serial_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/add32_byte_serial_ctrl.sv
// 32-bit add/subtract sequencer: one 8-bit Kogge-Stone slice reused
// over four cycles, LSB byte first, carry held between bytes.

module ks8_slice (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] sum,
  output logic       co
);

  logic [7:0] p;
  logic [7:0] g0;
  logic [7:0] g1;
  logic [7:0] p1;
  logic [7:0] g2;
  logic [7:0] p2;
  logic [7:0] g3;

  // carry-in folded into bit 0 generate; zero fill past bit 0
  assign p  = a ^ b;
  assign g0 = (a & b) | {7'b0, p[0] & ci};
  assign g1 = g0 | (p  & {g0[6:0], 1'b0});
  assign p1 = p  & {p[6:0], 1'b0};
  assign g2 = g1 | (p1 & {g1[5:0], 2'b0});
  assign p2 = p1 & {p1[5:0], 2'b0};
  assign g3 = g2 | (p2 & {g2[3:0], 4'b0});

  assign sum = p ^ {g3[6:0], ci};
  assign co  = g3[7];

endmodule

module add32_byte_serial_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic        cin,
  input  logic        op_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] s,
  output logic        cout,
  output logic        ovf,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  idx;
  logic [31:0] a;
  logic [31:0] b;
  logic        carry;
  logic        load;
  logic        step;
  logic        last;
  logic [7:0]  a_byte;
  logic [7:0]  b_byte;
  logic [7:0]  sum;
  logic        co;

  assign a_byte = a[{idx, 3'b000} +: 8];
  assign b_byte = b[{idx, 3'b000} +: 8];
  assign last   = (idx == 2'd3);

  ks8_slice u_slice (
    .a   (a_byte),
    .b   (b_byte),
    .ci  (carry),
    .sum (sum),
    .co  (co)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= 2'd0;
      a     <= 32'd0;
      b     <= 32'd0;
      carry <= 1'b0;
      s     <= 32'd0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        a     <= x1;
        b     <= op_sub ? ~x2 : x2;
        carry <= op_sub | cin;
        idx   <= 2'd0;
      end
      if (step) begin
        s[{idx, 3'b000} +: 8] <= sum;
        carry <= co;
        idx   <= idx + 2'd1;
        if (last) begin
          cout <= co;
          ovf  <= (a_byte[7] == b_byte[7]) && (sum[7] != a_byte[7]);
        end
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_add32_byte_serial_ctrl.sv
// Directed and randomized checks for add32_byte_serial_ctrl
// against hand-computed vectors and a 33-bit reference.

module tb_add32_byte_serial_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        cin;
  logic        op_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;
  logic        cout;
  logic        ovf;
  logic        busy;

  int checks;
  int failures;

  add32_byte_serial_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .cin       (cin),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, wait for the result, compare, then handshake.
  task automatic run_op(input string tag, input logic [31:0] a,
                        input logic [31:0] bb, input logic ci,
                        input logic sub, input logic [31:0] exp_s,
                        input logic exp_c, input logic exp_v,
                        input int stall);
    int n;
    logic [31:0] hold_s;
    logic        hold_c;
    logic        hold_v;
    check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    x1 = a; x2 = bb; cin = ci; op_sub = sub;
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, ".lat"}, n, 4);
    check({tag, ".s"}, s, exp_s);
    check({tag, ".cout"}, {31'd0, cout}, {31'd0, exp_c});
    check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, exp_v});
    if (stall > 0) begin
      hold_s = s; hold_c = cout; hold_v = ovf;
      in_valid = 1'b1;
      for (int i = 0; i < stall; i++) begin
        x1 = $urandom; x2 = $urandom;
        cin = 1'($urandom); op_sub = 1'($urandom);
        tick();
      end
      check({tag, ".bp_in_ready"}, {31'd0, in_ready}, 32'd0);
      check({tag, ".bp_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, ".bp_s"}, s, hold_s);
      check({tag, ".bp_flags"}, {30'd0, cout, ovf},
            {30'd0, hold_c, hold_v});
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".post_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".post_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    logic [32:0] ref_sum;
    longint sr;
    logic ref_v;
    logic [31:0] ra;
    logic [31:0] rb;
    logic rc;
    logic rs;

    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    x1 = $urandom; x2 = $urandom; cin = 1'b1; op_sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x1 = $urandom; x2 = $urandom;
      tick();
    end
    check("rst.flags", {28'd0, in_ready, out_valid, busy, cout},
          32'b1000);
    check("rst.s", s, 32'd0);
    check("rst.ovf", {31'd0, ovf}, 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b1;
    tick();

    // abort mid-RUN
    x1 = 32'h1234_5678; x2 = 32'h1; cin = 1'b0; op_sub = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("abort.busy_before", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort.now", {29'd0, in_ready, out_valid, busy}, 32'b100);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("abort.no_valid", seen, 0);
    check("abort.idle", {31'd0, in_ready}, 32'd1);

    run_op("carry_chain", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
           32'h0000_0000, 1'b1, 1'b0, 0);
    run_op("ovf_add", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
           32'h8000_0000, 1'b0, 1'b1, 0);
    run_op("ovf_sub", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1,
           32'h7FFF_FFFF, 1'b1, 1'b1, 0);
    run_op("borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1,
           32'hFFFF_FFFE, 1'b0, 1'b0, 0);
    run_op("add_cin", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0,
           32'h2345_678A, 1'b0, 1'b0, 0);
    run_op("sub_eq", 32'h0000_0010, 32'h0000_0010, 1'b0, 1'b1,
           32'h0000_0000, 1'b1, 1'b0, 0);
    run_op("backpressure", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0,
           32'h0100_0100, 1'b0, 1'b0, 10);

    for (int t = 0; t < 300; t++) begin
      ra = $urandom; rb = $urandom;
      rc = 1'($urandom); rs = 1'($urandom);
      if (t % 4 == 0) ra[31:24] = 8'hFF;
      if (t % 4 == 1) rb = ~ra;
      if (rs)
        ref_sum = {1'b0, ra} + {1'b0, ~rb} + 33'd1;
      else
        ref_sum = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      if (rs)
        sr = longint'($signed(ra)) - longint'($signed(rb));
      else
        sr = longint'($signed(ra)) + longint'($signed(rb))
             + longint'(rc);
      ref_v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      for (int w = $urandom_range(0, 2); w > 0; w--) tick();
      run_op("soak", ra, rb, rc, rs, ref_sum[31:0], ref_sum[32],
             ref_v, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
